alu_op_seq: RTL and testbench

//  Control sequencer that drives the nibble-serial ALU (module alu) through one 8-bit operation.

---
 rtl/alu_seq_pkg.sv | 47 ++++
 rtl/alu_flag_pack.sv | 43 ++++
 rtl/alu_op_seq.sv | 179 +++++++++++++++++
 tb/tb_alu_op_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the nibble-serial ALU sequencer.
// Holds the op and state encodings, the per-op R/S/V table and the flag bit positions.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_ADC = 3'd1,
    ALU_SUB = 3'd2,
    ALU_SBC = 3'd3,
    ALU_AND = 3'd4,
    ALU_XOR = 3'd5,
    ALU_OR  = 3'd6,
    ALU_CP  = 3'd7
  } aluop_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LD_A    = 3'd1,
    ST_LD_B_LO = 3'd2,
    ST_HI      = 3'd3,
    ST_OUT     = 3'd4
  } state_t;

  // {R,S,V} core function select, indexed by aluop_t: 001 adder, 100 AND, 010 XOR, 110 OR
  localparam logic [2:0] RSV_TABLE [8] = '{
    3'b001, 3'b001, 3'b001, 3'b001,
    3'b100, 3'b010, 3'b110, 3'b001
  };

  localparam int FLAG_S  = 7;
  localparam int FLAG_Z  = 6;
  localparam int FLAG_Y  = 5;
  localparam int FLAG_H  = 4;
  localparam int FLAG_X  = 3;
  localparam int FLAG_PV = 2;
  localparam int FLAG_N  = 1;
  localparam int FLAG_C  = 0;

  function automatic logic is_sub_class(aluop_t op);
    return (op == ALU_SUB) || (op == ALU_SBC) || (op == ALU_CP);
  endfunction

  function automatic logic is_logic_class(aluop_t op);
    return (op == ALU_AND) || (op == ALU_XOR) || (op == ALU_OR);
  endfunction

endpackage

// File: rtl/alu_flag_pack.sv
// Combinational assembly of the Z80 flag byte {S,Z,Y,H,X,PV,N,C}
// from the bits captured across the two nibble passes.
module alu_flag_pack
  import alu_seq_pkg::*;
(
  input  aluop_t      op_i,
  input  logic        hc_i,
  input  logic        carry_i,
  input  logic        vf_i,
  input  logic        sf_i,
  input  logic        yf_i,
  input  logic        xf_i,
  input  logic        parity_i,
  input  logic        zero_i,
  output logic [7:0]  flags_o
);

  always_comb begin
    flags_o         = 8'h00;
    flags_o[FLAG_S] = sf_i;
    flags_o[FLAG_Z] = zero_i;
    flags_o[FLAG_Y] = yf_i;
    flags_o[FLAG_X] = xf_i;
    // Subtraction runs as A + ~B + cin, so the ALU carries are inverted borrows
    if (is_sub_class(op_i)) begin
      flags_o[FLAG_H]  = ~hc_i;
      flags_o[FLAG_C]  = ~carry_i;
      flags_o[FLAG_N]  = 1'b1;
      flags_o[FLAG_PV] = vf_i;
    end else if (is_logic_class(op_i)) begin
      flags_o[FLAG_H]  = (op_i == ALU_AND);
      flags_o[FLAG_C]  = 1'b0;
      flags_o[FLAG_N]  = 1'b0;
      flags_o[FLAG_PV] = ~parity_i;
    end else begin
      flags_o[FLAG_H]  = hc_i;
      flags_o[FLAG_C]  = carry_i;
      flags_o[FLAG_N]  = 1'b0;
      flags_o[FLAG_PV] = vf_i;
    end
  end

endmodule

// File: rtl/alu_op_seq.sv
// Sequencer driving the nibble-serial ALU through one 8-bit operation:
// load A, load B + low nibble, high nibble, then present result and flags.
module alu_op_seq
  import alu_seq_pkg::*;
#(
  parameter int         OUT_CYCLES = 1,
  parameter logic [7:0] FLAG_RST   = 8'h00
)(
  input  logic        clk,
  input  logic        nreset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        cf_in,
  input  logic [7:0]  db,
  output logic        busy,
  output logic        done,
  output logic [1:0]  db_sel,
  output logic [7:0]  flags,
  output logic        alu_oe,
  output logic        alu_shift_oe,
  output logic        alu_res_oe,
  output logic        alu_op1_sel_bus,
  output logic        alu_op2_sel_bus,
  output logic        alu_sel_op2_neg,
  output logic        alu_sel_op2_high,
  output logic        alu_core_cf_in,
  output logic        alu_core_R,
  output logic        alu_core_S,
  output logic        alu_core_V,
  output logic        alu_op_low,
  output logic        alu_parity_in,
  input  logic        alu_core_cf_out,
  input  logic        alu_parity_out,
  input  logic        alu_zero,
  input  logic        alu_vf_out,
  input  logic        alu_sf_out,
  input  logic        alu_yf_out,
  input  logic        alu_xf_out
);

  localparam logic [1:0] OUT_LOAD = 2'(OUT_CYCLES - 1);

  state_t      state_q, state_d;
  aluop_t      op_q;
  logic        cf_q;
  logic [1:0]  cnt_q;
  logic        hc_q, p_lo_q, z_lo_q, y_cp_q, x_cp_q;
  logic [7:0]  flags_q, flags_d;
  logic        last_out, accept, low_cin, sub_op;
  logic        unused_db;

  assign unused_db = ^{db[7:6], db[4], db[2:0]};

  assign last_out = (state_q == ST_OUT) && (cnt_q == 2'd0);
  assign accept   = start && ((state_q == ST_IDLE) || last_out);
  assign sub_op   = is_sub_class(op_q);

  always_comb begin
    case (op_q)
      ALU_ADC:         low_cin = cf_q;
      ALU_SUB, ALU_CP: low_cin = 1'b1;
      ALU_SBC:         low_cin = ~cf_q;
      default:         low_cin = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = ST_LD_A;
      ST_LD_A:    state_d = ST_LD_B_LO;
      ST_LD_B_LO: state_d = ST_HI;
      ST_HI:      state_d = ST_OUT;
      ST_OUT:     if (cnt_q == 2'd0) state_d = accept ? ST_LD_A : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Flags are packed from the live HI-cycle ALU outputs so they are registered before done
  alu_flag_pack u_flag_pack (
    .op_i     (op_q),
    .hc_i     (hc_q),
    .carry_i  (alu_core_cf_out),
    .vf_i     (alu_vf_out),
    .sf_i     (alu_sf_out),
    .yf_i     ((op_q == ALU_CP) ? y_cp_q : alu_yf_out),
    .xf_i     ((op_q == ALU_CP) ? x_cp_q : alu_xf_out),
    .parity_i (alu_parity_out),
    .zero_i   (z_lo_q & alu_zero),
    .flags_o  (flags_d)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      op_q    <= ALU_ADD;
      cf_q    <= 1'b0;
      cnt_q   <= 2'd0;
      hc_q    <= 1'b0;
      p_lo_q  <= 1'b0;
      z_lo_q  <= 1'b0;
      y_cp_q  <= 1'b0;
      x_cp_q  <= 1'b0;
      flags_q <= FLAG_RST;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= aluop_t'(op);
        cf_q <= cf_in;
      end
      if (state_q == ST_HI) begin
        cnt_q   <= OUT_LOAD;
        flags_q <= flags_d;
      end else if ((state_q == ST_OUT) && (cnt_q != 2'd0)) begin
        cnt_q <= cnt_q - 2'd1;
      end
      if (state_q == ST_LD_B_LO) begin
        hc_q   <= alu_core_cf_out;
        p_lo_q <= alu_parity_out;
        z_lo_q <= alu_zero;
        y_cp_q <= db[5];
        x_cp_q <= db[3];
      end
    end
  end

  always_comb begin
    db_sel           = 2'b00;
    alu_oe           = 1'b0;
    alu_shift_oe     = 1'b0;
    alu_res_oe       = 1'b0;
    alu_op1_sel_bus  = 1'b0;
    alu_op2_sel_bus  = 1'b0;
    alu_sel_op2_neg  = 1'b0;
    alu_sel_op2_high = 1'b0;
    alu_core_cf_in   = 1'b0;
    alu_core_R       = 1'b0;
    alu_core_S       = 1'b0;
    alu_core_V       = 1'b0;
    alu_op_low       = 1'b0;
    alu_parity_in    = 1'b0;
    case (state_q)
      ST_LD_A: begin
        db_sel          = 2'b01;
        alu_shift_oe    = 1'b1;
        alu_op1_sel_bus = 1'b1;
      end
      ST_LD_B_LO: begin
        db_sel          = 2'b10;
        alu_shift_oe    = 1'b1;
        alu_op2_sel_bus = 1'b1;
        alu_op_low      = 1'b1;
        alu_sel_op2_neg = sub_op;
        alu_core_cf_in  = low_cin;
        {alu_core_R, alu_core_S, alu_core_V} = RSV_TABLE[op_q];
      end
      ST_HI: begin
        alu_sel_op2_high = 1'b1;
        alu_sel_op2_neg  = sub_op;
        alu_core_cf_in   = hc_q;
        alu_parity_in    = p_lo_q;
        {alu_core_R, alu_core_S, alu_core_V} = RSV_TABLE[op_q];
      end
      ST_OUT: begin
        alu_res_oe = 1'b1;
        alu_oe     = (op_q != ALU_CP);
      end
      default: ;
    endcase
  end

  assign busy  = (state_q != ST_IDLE);
  assign done  = last_out;
  assign flags = flags_q;

  a_oe_excl: assert property (@(posedge clk) disable iff (!nreset)
    !(alu_shift_oe && alu_res_oe));

endmodule

// File: tb/tb_alu_op_seq.sv
// Scoreboard bench for alu_op_seq with a behavioural nibble ALU and operand requester on db.
module tb_alu_op_seq;
  localparam logic [7:0] FLAG_RST_TB = 8'h00;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic        cf_in = 1'b0;
  logic [7:0]  db;
  logic        busy, done;
  logic [1:0]  db_sel;
  logic [7:0]  flags;
  logic        alu_oe, alu_shift_oe, alu_res_oe, alu_op1_sel_bus, alu_op2_sel_bus;
  logic        alu_sel_op2_neg, alu_sel_op2_high, alu_core_cf_in;
  logic        alu_core_R, alu_core_S, alu_core_V, alu_op_low, alu_parity_in;
  logic        alu_core_cf_out, alu_parity_out, alu_zero, alu_vf_out;
  logic        alu_sf_out, alu_yf_out, alu_xf_out;

  logic [7:0]  a_val = 8'h00, b_val = 8'h00;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  typedef struct {
    string      name;
    logic [7:0] exp_db;
    logic [7:0] exp_flags;
    logic       chk_db;
    logic       exp_cin;
    int         exp_done_cyc;
    logic       is_cp;
  } txn_t;
  txn_t sb_q[$];

  alu_op_seq #(.OUT_CYCLES(1), .FLAG_RST(FLAG_RST_TB)) dut (
    .clk(clk), .nreset(nreset), .start(start), .op(op), .cf_in(cf_in), .db(db),
    .busy(busy), .done(done), .db_sel(db_sel), .flags(flags),
    .alu_oe(alu_oe), .alu_shift_oe(alu_shift_oe), .alu_res_oe(alu_res_oe),
    .alu_op1_sel_bus(alu_op1_sel_bus), .alu_op2_sel_bus(alu_op2_sel_bus),
    .alu_sel_op2_neg(alu_sel_op2_neg), .alu_sel_op2_high(alu_sel_op2_high),
    .alu_core_cf_in(alu_core_cf_in), .alu_core_R(alu_core_R), .alu_core_S(alu_core_S),
    .alu_core_V(alu_core_V), .alu_op_low(alu_op_low), .alu_parity_in(alu_parity_in),
    .alu_core_cf_out(alu_core_cf_out), .alu_parity_out(alu_parity_out), .alu_zero(alu_zero),
    .alu_vf_out(alu_vf_out), .alu_sf_out(alu_sf_out), .alu_yf_out(alu_yf_out),
    .alu_xf_out(alu_xf_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural nibble ALU: {R,S,V} 001 add, 100 and, 010 xor, 110 or
  logic [7:0] op1_m = 8'h00, op2_m = 8'h00, op2_eff;
  logic [3:0] lo_m = 4'h0, hi_m = 4'h0, nib_a, nib_b, nib_r;
  logic [4:0] sum;
  logic [7:0] full_r;

  always @(posedge clk) begin
    if (alu_op1_sel_bus) op1_m <= db;
    if (alu_op2_sel_bus) op2_m <= db;
    if (alu_op_low) lo_m <= nib_r;
    if (alu_sel_op2_high) hi_m <= nib_r;
  end

  always_comb begin
    op2_eff = alu_op2_sel_bus ? db : op2_m;
    nib_a = alu_sel_op2_high ? op1_m[7:4] : op1_m[3:0];
    nib_b = alu_sel_op2_high ? op2_eff[7:4] : op2_eff[3:0];
    if (alu_sel_op2_neg) nib_b = ~nib_b;
    sum = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0, alu_core_cf_in};
    case ({alu_core_R, alu_core_S, alu_core_V})
      3'b100:  nib_r = nib_a & nib_b;
      3'b010:  nib_r = nib_a ^ nib_b;
      3'b110:  nib_r = nib_a | nib_b;
      default: nib_r = sum[3:0];
    endcase
    full_r = {nib_r, lo_m};
  end

  assign alu_core_cf_out = ({alu_core_R, alu_core_S, alu_core_V} == 3'b001) & sum[4];
  assign alu_parity_out  = alu_parity_in ^ (^nib_r);
  assign alu_zero        = (nib_r == 4'h0);
  assign alu_vf_out      = (nib_a[3] == nib_b[3]) && (sum[3] != nib_a[3]);
  assign alu_sf_out      = nib_r[3];
  assign alu_yf_out      = full_r[5];
  assign alu_xf_out      = full_r[3];

  assign db = alu_oe ? {hi_m, lo_m} :
              (db_sel == 2'b01) ? a_val :
              (db_sel == 2'b10) ? b_val : 8'h00;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse
  initial begin
    logic oe_seen;
    txn_t t;
    oe_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!nreset) begin
        oe_seen = 1'b0;
        continue;
      end
      if (alu_oe) oe_seen = 1'b1;
      if (db_sel == 2'b10 && sb_q.size() > 0)
        check({sb_q[0].name, "_cin"}, alu_core_cf_in, sb_q[0].exp_cin);
      if (done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          t = sb_q.pop_front();
          check({t.name, "_flags"}, flags, t.exp_flags);
          if (t.chk_db) check({t.name, "_db"}, db, t.exp_db);
          check({t.name, "_done_cycle"}, cyc, t.exp_done_cyc);
          if (t.is_cp) check({t.name, "_alu_oe_never"}, oe_seen, 0);
        end
        oe_seen = 1'b0;
      end
    end
  end

  task automatic push(input string nm, input logic [2:0] o, input logic [7:0] edb,
                      input logic [7:0] efl, input logic ecin, input int dcyc);
    txn_t t;
    t.name = nm; t.exp_db = edb; t.exp_flags = efl; t.chk_db = (o != 3'd7);
    t.exp_cin = ecin; t.exp_done_cyc = dcyc; t.is_cp = (o == 3'd7);
    sb_q.push_back(t);
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      check({nm, "_timeout"}, 1, 0);
      sb_q.delete();
    end
    @(posedge clk);
  endtask

  task automatic issue(input string nm, input logic [2:0] o, input logic [7:0] a,
                       input logic [7:0] b, input logic c, input logic [7:0] edb,
                       input logic [7:0] efl, input logic ecin);
    @(posedge clk); #1;
    op = o; cf_in = c; a_val = a; b_val = b; start = 1'b1;
    push(nm, o, edb, efl, ecin, cyc + 4);
    @(posedge clk); #1;
    start = 1'b0; op = ~o; cf_in = ~c;
    wait_drain(nm);
  endtask

  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_db_sel", db_sel, 2'b00);
    check("rst_flags", flags, FLAG_RST_TB);
    check("rst_ctl", {alu_oe, alu_shift_oe, alu_res_oe, alu_op1_sel_bus, alu_op2_sel_bus,
          alu_sel_op2_neg, alu_sel_op2_high, alu_core_cf_in, alu_core_R, alu_core_S,
          alu_core_V, alu_op_low, alu_parity_in}, 0);
    nreset = 1'b1;

    issue("add", 3'd0, 8'h8C, 8'h6D, 1'b0, 8'hF9, 8'hB8, 1'b0);
    issue("sub", 3'd2, 8'h10, 8'h01, 1'b0, 8'h0F, 8'h1A, 1'b1);
    issue("adc", 3'd1, 8'hFF, 8'h00, 1'b1, 8'h00, 8'h51, 1'b1);
    issue("and", 3'd4, 8'hF0, 8'h0F, 1'b0, 8'h00, 8'h54, 1'b0);
    issue("cp",  3'd7, 8'h05, 8'h05, 1'b0, 8'h00, 8'h42, 1'b1);
    issue("sbc", 3'd3, 8'h00, 8'h01, 1'b1, 8'hFE, 8'hBB, 1'b0);
    issue("or",  3'd6, 8'h81, 8'h02, 1'b0, 8'h83, 8'h80, 1'b0);
    issue("xor", 3'd5, 8'h5A, 8'h5A, 1'b0, 8'h00, 8'h44, 1'b0);
    issue("add_ovf", 3'd0, 8'h7F, 8'h01, 1'b0, 8'h80, 8'h94, 1'b0);

    // Back-to-back: start held through done, second op loaded during the first HI
    @(posedge clk); #1;
    base = cyc;
    op = 3'd0; cf_in = 1'b0; a_val = 8'h8C; b_val = 8'h6D; start = 1'b1;
    push("b2b_add", 3'd0, 8'hF9, 8'hB8, 1'b0, base + 4);
    repeat (3) @(posedge clk);
    #1;
    op = 3'd2; a_val = 8'h10; b_val = 8'h01;
    push("b2b_sub", 3'd2, 8'h0F, 8'h1A, 1'b1, base + 8);
    repeat (2) @(posedge clk);
    #1;
    check("b2b_no_gap_db_sel", db_sel, 2'b01);
    check("b2b_no_gap_busy", busy, 1);
    start = 1'b0;
    wait_drain("b2b");

    // Async abort during HI
    @(posedge clk); #1;
    op = 3'd0; cf_in = 1'b0; a_val = 8'h7F; b_val = 8'h01; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_in_hi", alu_sel_op2_high, 1);
    nreset = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_db_sel", db_sel, 2'b00);
    check("abort_flags", flags, FLAG_RST_TB);
    check("abort_ctl", {alu_oe, alu_shift_oe, alu_res_oe, alu_op1_sel_bus, alu_op2_sel_bus,
          alu_sel_op2_neg, alu_sel_op2_high, alu_core_cf_in, alu_core_R, alu_core_S,
          alu_core_V, alu_op_low, alu_parity_in, done}, 0);
    sb_q.delete();
    @(posedge clk); #1;
    nreset = 1'b1;
    issue("post_abort_sub", 3'd2, 8'h10, 8'h01, 1'b0, 8'h0F, 8'h1A, 1'b1);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
